sram_arbiter: RTL and testbench



---
 rtl/sram_arbiter_pkg.sv | 18 +
 rtl/sram_arbiter.sv | 158 +++++++++++++++
 tb/tb_sram_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter.
//   rsp_tag_e  : tag of the read currently in flight on the SRAM port
//   ADDR_W_DEF : default address width
//   DATA_W_DEF : default data width
//   BE_W       : byte-enable width of the SRAM port
package sram_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int BE_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_I = 2'd1,
        RD_D = 2'd2
    } rsp_tag_e;

endpackage : sram_arbiter_pkg

// File: rtl/sram_arbiter.sv
// Arbiter sharing one synchronous SRAM port between the instruction-fetch
// (i-side, read only) and load/store (d-side) requesters.
//   clk, rst                         : clock, asynchronous active-high reset
//   i_req/i_addr -> i_gnt            : i-side read request and its grant
//   i_rvalid/i_rdata                 : i-side read return, one cycle after grant
//   d_req/d_wen/d_addr/d_wdata -> d_gnt : d-side request (d_wen == 0 is a read)
//   d_rvalid/d_rdata                 : d-side read return, one cycle after grant
//   sram_en/wen/addr/wdata, sram_rdata : SRAM pins
// The d-side has priority; after MAX_WAIT consecutive lost cycles the i-side
// is forced to win the next collision.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic [BE_W-1:0]   d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              sram_en,
    output logic [BE_W-1:0]   sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int               CNT_W      = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};

    rsp_tag_e         state_r;
    rsp_tag_e         state_nxt_s;
    logic [CNT_W-1:0] wait_cnt_r;
    logic [CNT_W-1:0] wait_cnt_nxt_s;
    logic             i_win_s;
    logic             d_win_s;

    // Arbitration: d-side priority unless the i-side has waited MAX_WAIT cycles.
    // Grants are suppressed while reset is asserted.
    always_comb begin
        i_win_s = 1'b0;
        d_win_s = 1'b0;
        if (rst) begin
            i_win_s = 1'b0;
            d_win_s = 1'b0;
        end else if (i_req && d_req) begin
            if (wait_cnt_r == WAIT_LIMIT) begin
                i_win_s = 1'b1;
            end else begin
                d_win_s = 1'b1;
            end
        end else if (i_req) begin
            i_win_s = 1'b1;
        end else if (d_req) begin
            d_win_s = 1'b1;
        end else begin
            i_win_s = 1'b0;
            d_win_s = 1'b0;
        end
    end

    assign i_gnt = i_win_s;
    assign d_gnt = d_win_s;

    // SRAM pin mux: the winner drives the port; an i-side access is always a read.
    always_comb begin
        sram_en    = 1'b0;
        sram_wen   = {BE_W{1'b0}};
        sram_addr  = {ADDR_W{1'b0}};
        sram_wdata = {DATA_W{1'b0}};
        if (i_win_s) begin
            sram_en   = 1'b1;
            sram_addr = i_addr;
        end else if (d_win_s) begin
            sram_en    = 1'b1;
            sram_wen   = d_wen;
            sram_addr  = d_addr;
            sram_wdata = d_wdata;
        end else begin
            sram_en = 1'b0;
        end
    end

    // Anti-starvation counter: counts consecutive cycles the i-side requested
    // but lost, saturating at MAX_WAIT; any i-grant or idle i-side clears it.
    always_comb begin
        wait_cnt_nxt_s = CNT_ZERO;
        if (i_req && !i_win_s) begin
            if (wait_cnt_r == WAIT_LIMIT) begin
                wait_cnt_nxt_s = wait_cnt_r;
            end else begin
                wait_cnt_nxt_s = wait_cnt_r + CNT_ONE;
            end
        end else begin
            wait_cnt_nxt_s = CNT_ZERO;
        end
    end

    // State register and anti-starvation counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            wait_cnt_r <= CNT_ZERO;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
        end
    end

    // Response tag next state: every state re-evaluates the current grant so
    // back-to-back accesses pipeline without bubbles.
    always_comb begin
        state_nxt_s = IDLE;
        case (state_r)
            IDLE, RD_I, RD_D: begin
                if (i_win_s) begin
                    state_nxt_s = RD_I;
                end else if (d_win_s && (d_wen == {BE_W{1'b0}})) begin
                    state_nxt_s = RD_D;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Read-return strobes; gating with rst drops an in-flight read at once.
    always_comb begin
        i_rvalid = 1'b0;
        d_rvalid = 1'b0;
        if (rst) begin
            i_rvalid = 1'b0;
            d_rvalid = 1'b0;
        end else begin
            i_rvalid = (state_r == RD_I);
            d_rvalid = (state_r == RD_D);
        end
    end

    // Both requesters see the raw SRAM data, qualified by their own valid.
    assign i_rdata = sram_rdata;
    assign d_rdata = sram_rdata;

endmodule : sram_arbiter

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios with literal
// expectations, then randomized traffic, all checked every cycle against a
// transaction-level model with its own reference memory.
module tb_sram_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic [3:0]  d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata = 32'h0;

    int checks   = 0;
    int failures = 0;

    sram_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    // SRAM behavioural model driven by the DUT pins.
    logic [31:0] sram_mem [logic [31:0]];
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_wen != 4'h0) begin
                sram_mem[sram_addr] = merge(sram_mem.exists(sram_addr) ? sram_mem[sram_addr] : 32'h0,
                                            sram_wdata, sram_wen);
            end else begin
                sram_rdata <= sram_mem.exists(sram_addr) ? sram_mem[sram_addr] : 32'h0;
            end
        end
    end

    // Reference model: who should win, what the port should carry, and
    // which read (with which data) must come back next cycle.
    logic [31:0] ref_mem [logic [31:0]];
    int          lost = 0;      // consecutive cycles the i-side requested and lost
    int          pend = 0;      // 0 none, 1 i-side read, 2 d-side read in flight
    logic [31:0] pend_data = 32'h0;

    always @(negedge clk) begin
        logic ei;
        logic ed;
        if (rst) begin
            chk("rst_i_gnt", {31'b0, i_gnt}, 32'd0);
            chk("rst_d_gnt", {31'b0, d_gnt}, 32'd0);
            chk("rst_sram_en", {31'b0, sram_en}, 32'd0);
            chk("rst_sram_wen", {28'b0, sram_wen}, 32'd0);
            chk("rst_i_rvalid", {31'b0, i_rvalid}, 32'd0);
            chk("rst_d_rvalid", {31'b0, d_rvalid}, 32'd0);
            lost = 0;
            pend = 0;
        end else begin
            chk("m_i_rvalid", {31'b0, i_rvalid}, {31'b0, pend == 1});
            chk("m_d_rvalid", {31'b0, d_rvalid}, {31'b0, pend == 2});
            if (pend == 1) chk("m_i_rdata", i_rdata, pend_data);
            if (pend == 2) chk("m_d_rdata", d_rdata, pend_data);
            ei = i_req && (!d_req || lost >= MAX_WAIT);
            ed = d_req && !ei;
            chk("m_i_gnt", {31'b0, i_gnt}, {31'b0, ei});
            chk("m_d_gnt", {31'b0, d_gnt}, {31'b0, ed});
            chk("m_sram_en", {31'b0, sram_en}, {31'b0, ei || ed});
            if (ei) begin
                chk("m_sram_addr_i", sram_addr, i_addr);
                chk("m_sram_wen_i", {28'b0, sram_wen}, 32'd0);
                chk("m_sram_wdata_i", sram_wdata, 32'd0);
            end else if (ed) begin
                chk("m_sram_addr_d", sram_addr, d_addr);
                chk("m_sram_wen_d", {28'b0, sram_wen}, {28'b0, d_wen});
                chk("m_sram_wdata_d", sram_wdata, d_wdata);
            end
            lost = (i_req && !ei) ? lost + 1 : 0;
            pend = 0;
            if (ei) begin
                pend = 1;
                pend_data = ref_mem.exists(i_addr) ? ref_mem[i_addr] : 32'h0;
            end else if (ed) begin
                if (d_wen == 4'h0) begin
                    pend = 2;
                    pend_data = ref_mem.exists(d_addr) ? ref_mem[d_addr] : 32'h0;
                end else begin
                    ref_mem[d_addr] = merge(ref_mem.exists(d_addr) ? ref_mem[d_addr] : 32'h0,
                                            d_wdata, d_wen);
                end
            end
        end
    end

    task automatic set_in(input logic ir, input logic [31:0] ia, input logic dr,
                          input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd);
        @(posedge clk);
        #1;
        i_req = ir; i_addr = ia; d_req = dr; d_wen = dw; d_addr = da; d_wdata = dd;
    endtask

    function automatic logic [31:0] raddr();
        logic [31:0] base;
        base = ($urandom_range(0, 1) != 0) ? 32'h1000 : 32'h2000;
        return base + 32'($urandom_range(0, 3)) * 32'd4;
    endfunction

    initial begin
        logic gi;
        logic gd;
        rst = 1'b1;
        i_req = 1'b1; i_addr = 32'h1000;
        d_req = 1'b1; d_wen = 4'h0; d_addr = 32'h2000; d_wdata = 32'h0;
        sram_mem[32'h1000] = 32'hDEADBEEF; ref_mem[32'h1000] = 32'hDEADBEEF;
        sram_mem[32'h1004] = 32'hCAFEF00D; ref_mem[32'h1004] = 32'hCAFEF00D;

        // Reset held with both requesting, then release: d-side wins first.
        repeat (3) @(negedge clk);
        chk("lit_rst_i_gnt", {31'b0, i_gnt}, 32'd0);
        chk("lit_rst_d_gnt", {31'b0, d_gnt}, 32'd0);
        chk("lit_rst_sram_en", {31'b0, sram_en}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("lit_post_rst_d_gnt", {31'b0, d_gnt}, 32'd1);
        chk("lit_post_rst_i_gnt", {31'b0, i_gnt}, 32'd0);
        set_in(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);

        // Lone i-side read.
        set_in(1'b1, 32'h1000, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("lit_lone_i_gnt", {31'b0, i_gnt}, 32'd1);
        set_in(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("lit_lone_i_rvalid", {31'b0, i_rvalid}, 32'd1);
        chk("lit_lone_i_rdata", i_rdata, 32'hDEADBEEF);
        chk("lit_lone_d_rvalid", {31'b0, d_rvalid}, 32'd0);

        // Collision: d-side write wins, i-side follows.
        set_in(1'b1, 32'h1004, 1'b1, 4'hF, 32'h2000, 32'h12345678);
        @(negedge clk);
        chk("lit_col_d_gnt", {31'b0, d_gnt}, 32'd1);
        chk("lit_col_sram_wen", {28'b0, sram_wen}, 32'hF);
        set_in(1'b1, 32'h1004, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("lit_col_i_gnt", {31'b0, i_gnt}, 32'd1);
        chk("lit_col_no_d_rvalid", {31'b0, d_rvalid}, 32'd0);
        set_in(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("lit_col_i_rvalid", {31'b0, i_rvalid}, 32'd1);
        chk("lit_col_i_rdata", i_rdata, 32'hCAFEF00D);

        // Starvation: d wins cycles 0..3, i cycle 4, d again cycle 5.
        set_in(1'b1, 32'h1000, 1'b1, 4'h0, 32'h2000, 32'h0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("lit_starve_i_gnt_%0d", k), {31'b0, i_gnt}, (k == 4) ? 32'd1 : 32'd0);
            chk($sformatf("lit_starve_d_gnt_%0d", k), {31'b0, d_gnt}, (k == 4) ? 32'd0 : 32'd1);
        end
        set_in(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);

        // Pipelined alternation i, d, i.
        set_in(1'b1, 32'h1000, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        set_in(1'b0, 32'h0, 1'b1, 4'h0, 32'h2000, 32'h0);
        @(negedge clk);
        chk("lit_alt_i_rvalid0", {31'b0, i_rvalid}, 32'd1);
        chk("lit_alt_i_rdata0", i_rdata, 32'hDEADBEEF);
        set_in(1'b1, 32'h1004, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("lit_alt_d_rvalid", {31'b0, d_rvalid}, 32'd1);
        chk("lit_alt_d_rdata", d_rdata, 32'h12345678);
        set_in(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("lit_alt_i_rvalid1", {31'b0, i_rvalid}, 32'd1);
        chk("lit_alt_i_rdata1", i_rdata, 32'hCAFEF00D);

        // Reset in the cycle after a d-side read grant.
        set_in(1'b0, 32'h0, 1'b1, 4'h0, 32'h2000, 32'h0);
        @(negedge clk);
        chk("lit_rmid_d_gnt", {31'b0, d_gnt}, 32'd1);
        @(posedge clk); #1; rst = 1'b1; d_req = 1'b0;
        @(negedge clk);
        chk("lit_rmid_d_rvalid_rst", {31'b0, d_rvalid}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("lit_rmid_d_rvalid_after", {31'b0, d_rvalid}, 32'd0);

        // Randomized traffic, requests held until granted (occasionally dropped).
        gi = 1'b0;
        gd = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 199) == 0);
            if (!i_req || gi) begin
                i_req  = ($urandom_range(0, 2) != 0);
                i_addr = raddr();
            end else if ($urandom_range(0, 19) == 0) begin
                i_req = 1'b0;
            end
            if (!d_req || gd) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_addr  = raddr();
                d_wen   = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'h0;
                d_wdata = $urandom;
            end else if ($urandom_range(0, 19) == 0) begin
                d_req = 1'b0;
            end
            @(negedge clk);
            gi = i_gnt;
            gd = d_gnt;
        end

        set_in(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sram_arbiter
